// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
package muldiv_pkg;

  localparam int unsigned MULDIV_WIDTH = 32;
  localparam int unsigned MULDIV_ITER  = MULDIV_WIDTH;

  typedef enum logic [1:0] {
    MUL   = 2'b00,
    MULHU = 2'b01,
    DIVU  = 2'b10,
    REMU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

  function automatic logic op_is_div(input muldiv_op_t op);
    return (op == DIVU) || (op == REMU);
  endfunction

endpackage

// File: rtl/add_sub.sv
// Single carry-chain adder/subtractor. For subtraction cOut is the borrow.
module add_sub #(
  parameter int unsigned WIDTH = 33
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             add,
  output logic [WIDTH-1:0] y,
  output logic             cOut
);

  logic [WIDTH-1:0] b_eff;
  logic             carry;

  // Subtract as a + ~b + 1; the raw carry is "no borrow", so invert it.
  always_comb begin
    b_eff        = add ? b : ~b;
    {carry, y}   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, ~add};
    cOut         = add ? carry : ~carry;
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative unsigned multiply/divide sequencer: shift-add multiply and
// restoring divide over WIDTH iterations sharing one add_sub carry chain.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StartE,
  input  logic             FlushE,
  input  logic [1:0]       MulDivOpE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  output logic             BusyE,
  output logic             DoneE,
  output logic [WIDTH-1:0] MulDivResultE
);

  localparam int unsigned     CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  muldiv_state_t    state, state_nxt;
  muldiv_op_t       op_in, op_q;
  logic             is_div_q;

  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] hi_q;       // multiply: P high word; divide: remainder R
  logic [WIDTH-1:0] lo_q;       // multiply: P low word;  divide: quotient Q
  logic [WIDTH-1:0] hi_nxt, lo_nxt;
  logic [WIDTH-1:0] step_result;
  logic [WIDTH-1:0] result_q;
  logic [CNT_W-1:0] cnt_q;

  logic             load_run, load_dz, step, last_step;

  logic [WIDTH:0]   as_a, as_b, as_y;
  logic             as_add, as_cout;

  assign op_in         = muldiv_op_t'(MulDivOpE);
  assign is_div_q      = op_is_div(op_q);
  assign last_step     = step && (cnt_q == CNT_LAST);
  assign MulDivResultE = result_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state, stall/done outputs and datapath load strobes.
  always_comb begin
    state_nxt = state;
    load_run  = 1'b0;
    load_dz   = 1'b0;
    step      = 1'b0;
    BusyE     = 1'b0;
    DoneE     = 1'b0;
    unique case (state)
      IDLE: begin
        if (StartE && !FlushE) begin
          BusyE = 1'b1;
          if (op_is_div(op_in) && (SrcBE == '0)) begin
            load_dz   = 1'b1;
            state_nxt = DONE;
          end else begin
            load_run  = 1'b1;
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        BusyE = 1'b1;
        if (FlushE) begin
          state_nxt = IDLE;
        end else begin
          step = 1'b1;
          if (cnt_q == CNT_LAST) state_nxt = DONE;
        end
      end
      DONE: begin
        DoneE     = !FlushE;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand selection for the shared carry chain.
  always_comb begin
    if (is_div_q) begin
      as_add = 1'b0;
      as_a   = {hi_q, lo_q[WIDTH-1]};
      as_b   = {1'b0, b_q};
    end else begin
      as_add = 1'b1;
      as_a   = {1'b0, hi_q};
      as_b   = lo_q[0] ? {1'b0, b_q} : '0;
    end
  end

  add_sub #(.WIDTH(WIDTH + 1)) u_add_sub (
    .a    (as_a),
    .b    (as_b),
    .add  (as_add),
    .y    (as_y),
    .cOut (as_cout)
  );

  // One iteration's register update and the result word it would yield.
  always_comb begin
    if (is_div_q) begin
      hi_nxt = as_cout ? as_a[WIDTH-1:0] : as_y[WIDTH-1:0];
      lo_nxt = {lo_q[WIDTH-2:0], ~as_cout};
    end else begin
      hi_nxt = as_y[WIDTH:1];
      lo_nxt = {as_y[0], lo_q[WIDTH-1:1]};
    end
    step_result = lo_nxt;
    case (op_q)
      MULHU:   step_result = hi_nxt;
      REMU:    step_result = hi_nxt;
      default: step_result = lo_nxt;
    endcase
  end

  // Working registers, iteration counter and result register.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= MUL;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      if (load_run) begin
        op_q  <= op_in;
        b_q   <= SrcBE;
        hi_q  <= '0;
        lo_q  <= SrcAE;
        cnt_q <= '0;
      end else if (step) begin
        hi_q  <= hi_nxt;
        lo_q  <= lo_nxt;
        cnt_q <= cnt_q + 1'b1;
      end
      if (load_dz) begin
        result_q <= (op_in == DIVU) ? '1 : SrcAE;
      end else if (last_step) begin
        result_q <= step_result;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed cases plus random operations
// compared against a plain-arithmetic reference model.
module tb_muldiv_seq;

  logic        clk;
  logic        reset;
  logic        StartE;
  logic        FlushE;
  logic [1:0]  MulDivOpE;
  logic [31:0] SrcAE;
  logic [31:0] SrcBE;
  logic        BusyE;
  logic        DoneE;
  logic [31:0] MulDivResultE;

  int unsigned n_pass;
  int unsigned n_fail;
  int unsigned n_total;
  logic [31:0] last_result;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .StartE        (StartE),
    .FlushE        (FlushE),
    .MulDivOpE     (MulDivOpE),
    .SrcAE         (SrcAE),
    .SrcBE         (SrcBE),
    .BusyE         (BusyE),
    .DoneE         (DoneE),
    .MulDivResultE (MulDivResultE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (op)
      2'd0:    return p[31:0];
      2'd1:    return p[63:32];
      2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one operation and check busy/done timing and the result.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit disturb, input string tag);
    logic [31:0] exp;
    int          lat;
    int          bad;
    exp = model(op, a, b);
    lat = (op[1] && b == 0) ? 1 : 33;
    bad = 0;
    @(posedge clk); #1;
    StartE = 1'b1; MulDivOpE = op; SrcAE = a; SrcBE = b;
    @(negedge clk);
    check({tag, "_accept_busy_done"}, {30'd0, BusyE, DoneE}, 32'd2);
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      if (disturb && k >= 3 && k <= 5) begin
        StartE = 1'b1; MulDivOpE = ~op;
      end else begin
        StartE = 1'b0;
      end
      SrcAE = $urandom; SrcBE = $urandom;
      @(negedge clk);
      if (k < lat && (BusyE !== 1'b1 || DoneE !== 1'b0)) bad++;
    end
    check({tag, "_busy_window"}, 32'(bad), 32'd0);
    check({tag, "_done_busy_done"}, {30'd0, BusyE, DoneE}, 32'd1);
    check({tag, "_result"}, MulDivResultE, exp);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_after_done"}, {31'd0, DoneE}, 32'd0);
    check({tag, "_hold"}, MulDivResultE, exp);
    last_result = exp;
  endtask

  initial begin
    int          bad;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    n_pass = 0; n_fail = 0; n_total = 0; last_result = '0;
    reset = 1'b1; StartE = 1'b0; FlushE = 1'b0; MulDivOpE = 2'd0; SrcAE = '0; SrcBE = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", {31'd0, BusyE}, 32'd0);
    check("reset_done", {31'd0, DoneE}, 32'd0);
    check("reset_result", MulDivResultE, 32'd0);
    @(posedge clk); #1; reset = 1'b0;

    // Directed cases
    run_op(2'd0, 32'd7, 32'd6, 1'b0, "mul_7x6");
    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mul_ff");
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mulhu_ff");
    run_op(2'd2, 32'd100, 32'd7, 1'b0, "divu_100_7");
    run_op(2'd3, 32'd100, 32'd7, 1'b0, "remu_100_7");
    run_op(2'd2, 32'h8000_0000, 32'd1, 1'b0, "divu_msb_1");
    run_op(2'd2, 32'd5, 32'd0, 1'b0, "divu_by0");
    run_op(2'd3, 32'd5, 32'd0, 1'b0, "remu_by0");
    run_op(2'd0, 32'd0, 32'h1234_5678, 1'b0, "mul_by0");
    run_op(2'd1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, "mulhu_ignore_start");

    // StartE with FlushE in IDLE is not accepted
    @(posedge clk); #1;
    StartE = 1'b1; FlushE = 1'b1; MulDivOpE = 2'd0; SrcAE = 32'd3; SrcBE = 32'd3;
    @(negedge clk);
    check("flush_idle_busy", {31'd0, BusyE}, 32'd0);
    @(posedge clk); #1; StartE = 1'b0; FlushE = 1'b0;
    @(negedge clk);
    check("flush_idle_not_started", {30'd0, BusyE, DoneE}, 32'd0);

    // Flush in RUN at t+10
    @(posedge clk); #1;
    StartE = 1'b1; MulDivOpE = 2'd0; SrcAE = 32'd11; SrcBE = 32'd13;
    @(posedge clk); #1; StartE = 1'b0;
    repeat (9) @(posedge clk);
    #1 FlushE = 1'b1;
    @(negedge clk);
    check("flush_run_busy", {31'd0, BusyE}, 32'd1);
    @(posedge clk); #1; FlushE = 1'b0;
    @(negedge clk);
    check("flush_after_busy_done", {30'd0, BusyE, DoneE}, 32'd0);
    check("flush_result_kept", MulDivResultE, last_result);
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (DoneE !== 1'b0 || BusyE !== 1'b0 || MulDivResultE !== last_result) bad++;
    end
    check("flush_no_done", 32'(bad), 32'd0);
    run_op(2'd2, 32'd9, 32'd3, 1'b0, "divu_9_3_after_flush");

    // Random operations
    for (int i = 0; i < 16; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      if (i % 5 == 0)      rb = 32'd0;
      else if (i % 3 == 0) rb = 32'($urandom_range(1, 15));
      else                 rb = $urandom;
      run_op(rop, ra, rb, (i % 4 == 1), $sformatf("rand%0d_op%0d", i, rop));
    end

    // Reset in the middle of RUN
    @(posedge clk); #1;
    StartE = 1'b1; MulDivOpE = 2'd0; SrcAE = 32'd21; SrcBE = 32'd2;
    @(posedge clk); #1; StartE = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    check("midreset_busy_done", {30'd0, BusyE, DoneE}, 32'd0);
    check("midreset_result", MulDivResultE, 32'd0);
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (DoneE !== 1'b0 || BusyE !== 1'b0) bad++;
    end
    check("midreset_no_done", 32'(bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
